// File: rtl/neuron_bitstream_acc.sv
// ---------------------------------------------------------------------------
// neuron_bitstream_acc
//
// Purpose:
//   This is a stochastic neuron. It combines INPUT_SIZE unipolar input
//   bitstreams with per-input weight generators and a bias generator.
//   MODE 0 ORs the products together with the bias bit (OR-accumulate).
//   MODE 1 selects one term per cycle in round-robin order, which gives a
//   scaled add. A frame counter turns the output bitstream into a binary
//   popcount over FRAME_LEN cycles. The frame uses a start/done/ack handshake.
//
// Optional feature (macro NEURON_STREAM_GATE_EN):
//   When this macro is defined, neuron_output reads 0 whenever the FSM is
//   not in RUN. The registered sum keeps updating underneath, so RUN starts
//   with no extra latency.
//
// Ports:
//   clk           in   rising-edge clock
//   n_rst         in   asynchronous active-low reset
//   neuron_input  in   [INPUT_SIZE]  one bit per input bitstream per cycle
//   weight_values in   int[INPUT_SIZE] weight thresholds (p = x/256)
//   bias_value    in   int           bias threshold (p = x/256)
//   start         in   pulse that begins a counting frame
//   ack           in   consumer acknowledges the count
//   neuron_output out  registered output bitstream
//   busy          out  high while a frame is being counted
//   done          out  count valid, held until ack
//   count         out  [CNT_W] number of 1s in the last frame
// ---------------------------------------------------------------------------

// Stochastic number generator. Outputs a Bernoulli bit with p = value/256.
// The random byte comes from the top byte of a 16-bit maximal-length LFSR.
module neuron_bitstream_sng #(
    parameter int SEED = 0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic signed [31:0] value,
    output logic               bit_out
);

    // The LFSR must never hold zero. Scramble the seed and fall back to 1
    // in the single case where the scrambled value would be zero.
    function automatic logic [15:0] seed_init(input int s);
        logic [15:0] v;
        v = s[15:0] ^ 16'hACE1;
        if (v == 16'h0000) begin
            v = 16'h0001;
        end
        return v;
    endfunction

    localparam logic [15:0] INIT = seed_init(SEED);

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr <= INIT;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_comb begin
        bit_out = 1'b0;
        if (value <= 0) begin
            bit_out = 1'b0;
        end else if (value >= 256) begin
            bit_out = 1'b1;
        end else begin
            bit_out = (lfsr[15:8] < value[7:0]);
        end
    end

endmodule

module neuron_bitstream_acc #(
    parameter int INPUT_SIZE = 2,
    parameter int SEED       = 0,
    parameter int MODE       = 0,
    parameter int FRAME_LEN  = 256,
    parameter int CNT_W      = $clog2(FRAME_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [INPUT_SIZE-1:0] neuron_input,
    input  logic signed [31:0]    weight_values [INPUT_SIZE],
    input  logic signed [31:0]    bias_value,
    input  logic                  start,
    input  logic                  ack,
    output logic                  neuron_output,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [INPUT_SIZE-1:0] weight_bit;
    logic [INPUT_SIZE-1:0] mult;
    logic                  bias_bit;
    logic                  sum;
    logic                  sum_q;

    state_t                state;
    logic [CNT_W-1:0]      acc;
    logic [CNT_W-1:0]      fcnt;

    // ---------------------------------------------------------------------
    // Generators
    // ---------------------------------------------------------------------
    neuron_bitstream_sng #(.SEED(SEED + 1)) u_bias_sng (
        .clk     (clk),
        .n_rst   (n_rst),
        .value   (bias_value),
        .bit_out (bias_bit)
    );

    for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_weight
        neuron_bitstream_sng #(.SEED(SEED + i + 2)) u_weight_sng (
            .clk     (clk),
            .n_rst   (n_rst),
            .value   (weight_values[i]),
            .bit_out (weight_bit[i])
        );
    end

    assign mult = neuron_input & weight_bit;

    // ---------------------------------------------------------------------
    // Sum stage
    // ---------------------------------------------------------------------
    if (MODE == 0) begin : g_or_acc
        assign sum = bias_bit | (|mult);
    end else begin : g_mux_add
        localparam int SEL_W = $clog2(INPUT_SIZE + 1);
        localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(INPUT_SIZE);

        logic [SEL_W-1:0]    sel;
        logic [INPUT_SIZE:0] terms;

        // The bias sits just above the products, so one index covers every
        // slot in the round-robin, including sel == INPUT_SIZE.
        assign terms = {bias_bit, mult};
        assign sum   = terms[sel];

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                sel <= '0;
            end else if (sel == SEL_LAST) begin
                sel <= '0;
            end else begin
                sel <= sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sum_q <= 1'b0;
        end else begin
            sum_q <= sum;
        end
    end

`ifdef NEURON_STREAM_GATE_EN
    // Gate the output with the registered state, so it stays glitch-free.
    assign neuron_output = sum_q & (state == S_RUN);
`else
    assign neuron_output = sum_q;
`endif

    // ---------------------------------------------------------------------
    // Frame counter FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            acc   <= '0;
            fcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        acc   <= '0;
                        fcnt  <= '0;
                    end
                end
                S_RUN: begin
                    if (fcnt == LAST) begin
                        // The final sample goes straight into count.
                        // acc itself never has to hold FRAME_LEN.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        count <= acc + CNT_W'(neuron_output);
                    end else begin
                        acc  <= acc + CNT_W'(neuron_output);
                        fcnt <= fcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        done <= 1'b0;
                        if (start) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            acc   <= '0;
                            fcnt  <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
